// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter that shares one IEEE-754 single multiplier between two requesters.
// Zero operands are answered directly; a stalled datapath is cut off after TIMEOUT wait cycles.
module fp_mul_arbiter #(
  parameter int unsigned TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_done,
  input  logic [31:0] mul_result,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_err,
  input  logic        rsp_ready,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // reqN_ready is only raised in IDLE; rsp_valid holds with stable fields until rsp_ready.

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] result_q, result_d;
  logic        id_q, id_d;
  logic        err_q, err_d;
  logic        last_grant_q, last_grant_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        grant_id;
  logic        any_valid;
  logic [31:0] sel_a, sel_b;
  logic        sel_zero;

  // Both valid: serve the one not served last; otherwise serve whoever asks.
  assign any_valid = req0_valid | req1_valid;
  assign grant_id  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  assign sel_a     = grant_id ? req1_a : req0_a;
  assign sel_b     = grant_id ? req1_b : req0_b;
  assign sel_zero  = (sel_a[30:0] == 31'd0) || (sel_b[30:0] == 31'd0);

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    id_d         = id_q;
    err_d        = err_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          a_d          = sel_a;
          b_d          = sel_b;
          id_d         = grant_id;
          last_grant_d = grant_id;
          if (sel_zero) begin
            result_d = {sel_a[31] ^ sel_b[31], 31'd0};
            err_d    = 1'b0;
            state_d  = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mul_done) begin
          result_d = mul_result;
          err_d    = 1'b0;
          state_d  = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          result_d = QNAN;
          err_d    = 1'b1;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      result_q     <= 32'd0;
      id_q         <= 1'b0;
      err_q        <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      id_q         <= id_d;
      err_q        <= err_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  logic in_flight;
  assign in_flight  = (state_q == S_ISSUE) || (state_q == S_WAIT);

  assign req0_ready = (state_q == S_IDLE) && req0_valid && !grant_id;
  assign req1_ready = (state_q == S_IDLE) && req1_valid && grant_id;
  assign mul_start  = (state_q == S_ISSUE);
  assign mul_a      = in_flight ? a_q : 32'd0;
  assign mul_b      = in_flight ? b_q : 32'd0;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_id     = rsp_valid & id_q;
  assign rsp_result = rsp_valid ? result_q : 32'd0;
  assign rsp_err    = rsp_valid & err_q;
  assign busy       = (state_q != S_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: doc/fp_mul_arbiter.md
FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 63: maximum WAIT cycles allowed for mul_done before abort; legal range 2..255.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req0_valid  in  1  requester 0 has an operand pair.
REQ-005 req0_a, req0_b  in  32 each  requester 0 IEEE-754 single operands.
REQ-006 req0_ready  out  1  requester 0 operands accepted this cycle.
REQ-007 req1_valid, req1_a, req1_b, req1_ready  same as REQ-004..006, requester 1.
REQ-008 mul_start  out  1  one-cycle start pulse to the shared multiplier datapath.
REQ-009 mul_a, mul_b  out  32 each  operands to the datapath.
REQ-010 mul_done  in  1  datapath result valid, single-cycle pulse.
REQ-011 mul_result  in  32  datapath product.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_id  out  1  requester index the response belongs to.
REQ-014 rsp_result  out  32  product.
REQ-015 rsp_err  out  1  datapath timeout.
REQ-016 rsp_ready  in  1  consumer accepts response.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, RESP; exactly one transaction in flight.
REQ-019 IDLE: reqN_ready high only for the granted requester; both low in every other state.
REQ-020 Grant: one valid -> that requester; both valid -> requester != last_grant (round-robin).
REQ-021 Handshake valid&&ready: latch a, b, id; last_grant <= id; next state ISSUE, or RESP if zero-bypass.
REQ-022 Zero-bypass: operand bits[30:0]==0 on either input -> rsp_result = {a[31]^b[31], 31'b0}, rsp_err=0, no mul_start.
REQ-023 ISSUE: mul_start=1 for exactly one cycle; next state WAIT; wait counter cleared to 0.
REQ-024 mul_a/mul_b = latched operands, stable from ISSUE until leaving WAIT; 0 in IDLE.
REQ-025 WAIT: mul_done=1 -> capture mul_result, rsp_err=0, go RESP.
REQ-026 WAIT, mul_done=0: counter increments; mul_done still 0 with counter==TIMEOUT-1 -> rsp_result=32'h7FC00000, rsp_err=1, go RESP (WAIT lasts at most TIMEOUT cycles).
REQ-027 mul_done outside WAIT (IDLE, ISSUE, RESP, late after timeout) ignored.
REQ-028 RESP: rsp_valid=1; rsp_id/rsp_result/rsp_err held stable until rsp_ready=1; then IDLE next cycle.
REQ-029 rsp_ready while rsp_valid=0 has no effect.
REQ-030 New request acceptance earliest the cycle after leaving RESP (no RESP->accept overlap).
REQ-031 Request lines sampled only in IDLE; deassertion of reqN_valid before grant drops nothing.

Reset
REQ-032 rst=1 at any time (including mid-WAIT) forces IDLE immediately: all outputs 0, counter 0, latched operands 0, last_grant=1 (requester 0 first priority); in-flight transaction discarded, no response issued.
REQ-033 After rst release, first acceptance possible on the first rising edge with rst=0.

Verification
REQ-034 req0 0x40000000 x 0x40400000, model latency 5, rsp_ready=1 -> one mul_start, rsp_valid with id=0, result 0x40C00000, err=0.
REQ-035 req0 and req1 held valid continuously after reset -> grants 0,1,0,1; each pair separated by full ISSUE/WAIT/RESP.
REQ-036 req1 0x80000000 x 0x40400000 -> no mul_start, RESP one cycle after acceptance, result 0x80000000, id=1.
REQ-037 TIMEOUT=8, mul_done never asserted -> RESP after 8 WAIT cycles, result 0x7FC00000, err=1; mul_done pulse two cycles later ignored.
REQ-038 rsp_ready low 10 cycles in RESP -> response fields unchanged, both reqN_ready low; transaction completes on rsp_ready=1.
REQ-039 rst pulsed during WAIT -> outputs 0 immediately, no response, subsequent req0 served normally.
